serial_subtractor: RTL and testbench



---
 rtl/arith_pkg.sv | 12 +
 rtl/half_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells: FSM states and default width.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/half_subtractor.sv
// Gate-level half subtractor: D = x ^ y, Bo = ~x & y.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic D,
  output logic Bo
);

  logic x_n;

  xor g_diff   (D, x, y);
  not g_inv    (x_n, x);
  and g_borrow (Bo, x_n, y);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor cell plus a borrow flop.
// Diff/Bout are registered and only change when a run completes (or on reset).
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Full-subtractor cell built from two half subtractors
  logic d1, bo1, bit_d, bo2, bit_bo;

  half_subtractor u_hs1 (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .D  (d1),
    .Bo (bo1)
  );

  half_subtractor u_hs2 (
    .x  (d1),
    .y  (borrow_q),
    .D  (bit_d),
    .Bo (bo2)
  );

  assign bit_bo = bo1 | bo2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = A;
          b_sh_d   = B;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = {bit_d, res_q[WIDTH-1:1]};
        borrow_d = bit_bo;
        // Counter saturates at the last bit index instead of wrapping
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          diff_d = {bit_d, res_q[WIDTH-1:1]};
          bout_d = bit_bo;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    Diff = diff_q;
    Bout = bout_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: an 8-bit instance driven by directed and random traffic against a
// transaction-level timing model, plus a 4-bit instance swept over all operand pairs.
module tb_serial_subtractor;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst8, start8, busy8, done8, bout8;
  logic [W8-1:0] a8, b8, diff8;
  logic          rst4, start4, busy4, done4, bout4;
  logic [W4-1:0] a4, b4, diff4;

  serial_subtractor #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Diff(diff8), .Bout(bout8)
  );

  serial_subtractor #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .Diff(diff4), .Bout(bout4)
  );

  typedef struct {
    logic [W8-1:0] diff;
    logic          bout;
    int            due;
  } exp8_t;

  typedef struct {
    logic [W4-1:0] diff;
    logic          bout;
  } exp4_t;

  exp8_t q8[$];
  exp4_t q4[$];

  int total = 0;
  int bad   = 0;

  int            edge_n    = 0;
  int            next_free = 0;
  int            busy_end  = 0;
  bit            active    = 1'b0;
  logic [W8-1:0] held_diff = '0;
  logic          held_bout = 1'b0;
  bit            mon8_en   = 1'b0;
  bit            mon4_en   = 1'b0;
  int            n_done4   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for the 8-bit instance: decides at each edge whether a start is
  // accepted and when its result is due, from the operation's cycle budget alone.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst8 === 1'b1) begin
        q8.delete();
        held_diff = '0;
        held_bout = 1'b0;
        active    = 1'b0;
        next_free = edge_n + 1;
      end else if (start8 === 1'b1 && edge_n >= next_free) begin
        exp8_t e;
        e.diff    = a8 - b8;
        e.bout    = (a8 < b8);
        e.due     = edge_n + W8;
        q8.push_back(e);
        active    = 1'b1;
        busy_end  = edge_n + W8;
        next_free = edge_n + W8 + 2;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon8_en) begin
        chk("busy8", 32'(busy8), 32'(active && (edge_n <= busy_end)));
        if (q8.size() > 0 && q8[0].due == edge_n) begin
          exp8_t e;
          e = q8.pop_front();
          chk("done8", 32'(done8), 32'(1));
          chk("diff8", 32'(diff8), 32'(e.diff));
          chk("bout8", 32'(bout8), 32'(e.bout));
          held_diff = e.diff;
          held_bout = e.bout;
        end else begin
          chk("done8_low", 32'(done8), 32'(0));
          chk("diff8_hold", 32'(diff8), 32'(held_diff));
          chk("bout8_hold", 32'(bout8), 32'(held_bout));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon4_en && done4 === 1'b1) begin
        n_done4++;
        if (q4.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done4_unexpected: got done with empty scoreboard (t=%0t)", $time);
        end else begin
          exp4_t e;
          e = q4.pop_front();
          chk("diff4", 32'(diff4), 32'(e.diff));
          chk("bout4", 32'(bout4), 32'(e.bout));
        end
      end
    end
  end

  task automatic op8(input logic [W8-1:0] a, input logic [W8-1:0] b);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    a8 = W8'($urandom);
    b8 = W8'($urandom);
    repeat (11) @(negedge clk);
  endtask

  task automatic stim8();
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    @(negedge clk);
    mon8_en = 1'b1;
    start8 = 1'b1;
    a8 = 8'h12;
    b8 = 8'h34;
    @(negedge clk);
    rst8 = 1'b0;
    start8 = 1'b0;
    @(negedge clk);

    op8(8'h5A, 8'h3C);
    op8(8'h00, 8'h01);
    op8(8'hFF, 8'hFF);

    // starts re-issued while running and while done must be dropped
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C;
    @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      start8 = (k == 3 || k == 9);
      a8 = 8'h10;
      b8 = 8'h01;
      @(negedge clk);
    end
    start8 = 1'b0;

    // reset mid-run discards the partial result
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'h21;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    op8(8'h80, 8'h7F);

    start8 = 1'b1;
    repeat (40) begin
      a8 = W8'($urandom);
      b8 = W8'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    repeat (600) begin
      start8 = ($urandom_range(0, 3) == 0);
      rst8   = ($urandom_range(0, 80) == 0);
      a8     = W8'($urandom);
      b8     = W8'($urandom);
      @(negedge clk);
    end
    rst8 = 1'b0;
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'(0));
  endtask

  task automatic stim4();
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    rst4 = 1'b0;
    mon4_en = 1'b1;
    chk("busy4_reset", 32'(busy4), 32'(0));
    chk("diff4_reset", 32'(diff4), 32'(0));
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp4_t e;
        e.diff = W4'(a - b);
        e.bout = (a < b);
        q4.push_back(e);
        start4 = 1'b1;
        a4 = W4'(a);
        b4 = W4'(b);
        @(negedge clk);
        start4 = 1'b0;
        repeat (W4 + 1) @(negedge clk);
      end
    end
    repeat (8) @(negedge clk);
    chk("n_done4", 32'(n_done4), 32'(256));
    chk("q4_drained", 32'(q4.size()), 32'(0));
  endtask

  initial begin
    fork
      stim8();
      stim4();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
